usb_burst_cache: RTL and testbench

USB_BURST_CACHE -- requirements
Module: usb_burst_cache

---
 rtl/usb_burst_cache.sv | 157 +++++++++++++++
 tb/tb_usb_burst_cache.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_burst_cache.sv
// Circular sample cache: USB words are written whenever usb_rd_state==WR_CODE,
// and a falling edge on USB3_FLAGA streams exactly BURST_LEN words out on q.
module usb_burst_cache #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BURST_LEN = 256,
  parameter int unsigned LANES     = 16,
  parameter logic [3:0]  WR_CODE   = 4'd6
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic [3:0]        usb_rd_state,
  input  logic              USB3_FLAGA,
  input  logic              clear_err,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic [LANES-1:0]  wren_for_ram,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow,
  output logic              burst_done
);

  localparam int unsigned       DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   BURST_LVL = (ADDR_W+1)'(BURST_LEN);
  localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_CNT  = ADDR_W'(BURST_LEN - 1);

  generate
    if (BURST_LEN < 1 || BURST_LEN > DEPTH) begin : g_bad_burst_len
      $error("usb_burst_cache: BURST_LEN must lie in 1..2**ADDR_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] burst_cnt;
  logic              flag_s1, flag_s2, flag_s3;
  logic              fall_evt;
  logic              wr_req, wr_acc, rd_iss, last_rd;
  logic              start_burst, short_burst;

  assign full        = (level == DEPTH_LVL);
  assign empty       = (level == '0);
  assign fall_evt    = flag_s3 & ~flag_s2;
  assign wr_req      = (usb_rd_state == WR_CODE);
  assign wr_acc      = wr_req & ~full;
  assign rd_iss      = (state == STREAM);
  assign last_rd     = rd_iss && (burst_cnt == LAST_CNT);
  assign start_burst = (state == IDLE) && fall_evt && (level >= BURST_LVL);
  assign short_burst = (state == IDLE) && fall_evt && (level <  BURST_LVL);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_burst) state_nxt = STREAM;
      STREAM:  if (last_rd)     state_nxt = DONE;
      DONE:                     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // flag_s3 only remembers the previous synchronized value for edge detection
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      flag_s1 <= 1'b1;
      flag_s2 <= 1'b1;
      flag_s3 <= 1'b1;
    end else begin
      flag_s1 <= USB3_FLAGA;
      flag_s2 <= flag_s1;
      flag_s3 <= flag_s2;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start_burst)
        burst_cnt <= '0;
      else if (rd_iss)
        burst_cnt <= burst_cnt + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_acc)
      mem[wr_ptr] <= data;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_iss)
        rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({wr_acc, rd_iss})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      q            <= '0;
      q_valid      <= 1'b0;
      wren_for_ram <= '0;
      burst_done   <= 1'b0;
    end else begin
      if (rd_iss)
        q <= mem[rd_ptr];
      q_valid      <= rd_iss;
      wren_for_ram <= rd_iss ? '1 : '0;
      burst_done   <= last_rd;
    end
  end

  // a fresh error event takes priority over a simultaneous clear
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_req && full)
        overflow <= 1'b1;
      else if (clear_err)
        overflow <= 1'b0;
      if (short_burst)
        underflow <= 1'b1;
      else if (clear_err)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_burst_cache.sv
// Bench for usb_burst_cache: a queue-based model of the cache is compared
// against the DUT on every falling clock edge, plus directed literal checks.
module tb_usb_burst_cache;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic [3:0]  usb_rd_state = '0;
  logic        USB3_FLAGA = 1'b1;
  logic        clear_err = 1'b0;
  logic [31:0] q;
  logic        q_valid;
  logic [15:0] wren_for_ram;
  logic [8:0]  level;
  logic        full, empty, overflow, underflow, burst_done;

  usb_burst_cache #(
    .DATA_W(32), .ADDR_W(8), .BURST_LEN(256), .LANES(16), .WR_CODE(4'd6)
  ) dut (
    .clock(clock), .rst_n(rst_n), .data(data), .usb_rd_state(usb_rd_state),
    .USB3_FLAGA(USB3_FLAGA), .clear_err(clear_err), .q(q), .q_valid(q_valid),
    .wren_for_ram(wren_for_ram), .level(level), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow), .burst_done(burst_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the cache is a queue of words, a burst is a countdown.
  logic [31:0] mq[$];
  logic [31:0] m_q;
  bit          m_qv, m_done, m_ov, m_un;
  int          left, sz;
  bit          done_cyc, h1, h2, h3, fall, ov_ev, un_ev, do_wr;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_q = '0; m_qv = 0; m_done = 0; m_ov = 0; m_un = 0;
      left = 0; done_cyc = 0; h1 = 1; h2 = 1; h3 = 1;
    end else begin
      sz    = mq.size();
      fall  = h3 && !h2;
      ov_ev = 0;
      un_ev = 0;
      do_wr = (usb_rd_state == 4'd6);
      if (do_wr && sz >= 256) begin
        ov_ev = 1;
        do_wr = 0;
      end
      m_done = 0;
      if (left > 0) begin
        m_q  = mq.pop_front();
        m_qv = 1;
        left--;
        if (left == 0) begin
          m_done   = 1;
          done_cyc = 1;
        end
      end else begin
        m_qv = 0;
        if (done_cyc) done_cyc = 0;
        else if (fall) begin
          if (sz >= 256) left = 256;
          else un_ev = 1;
        end
      end
      if (do_wr) mq.push_back(data);
      if (ov_ev) m_ov = 1; else if (clear_err) m_ov = 0;
      if (un_ev) m_un = 1; else if (clear_err) m_un = 0;
      h3 = h2; h2 = h1; h1 = USB3_FLAGA;
    end
  end

  bit started = 0;
  int dut_qv_cnt = 0;
  int dut_done_cnt = 0;

  always @(negedge clock) begin
    if (started) begin
      chk("q", q, m_q);
      chk("q_valid", q_valid, m_qv);
      chk("wren_for_ram", wren_for_ram, m_qv ? 16'hffff : 16'h0000);
      chk("level", level, mq.size());
      chk("full", full, mq.size() == 256);
      chk("empty", empty, mq.size() == 0);
      chk("overflow", overflow, m_ov);
      chk("underflow", underflow, m_un);
      chk("burst_done", burst_done, m_done);
      if (q_valid) dut_qv_cnt++;
      if (burst_done) dut_done_cnt++;
    end
  end

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      usb_rd_state = 4'd6;
      data = 32'(base + i);
    end
    @(negedge clock);
    usb_rd_state = 4'd0;
  endtask

  task automatic drop_flag(input int wait_cycles);
    @(negedge clock);
    USB3_FLAGA = 1'b0;
    repeat (4) @(negedge clock);
    USB3_FLAGA = 1'b1;
    repeat (wait_cycles) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_q_valid", q_valid, 1'b0);
    chk("rst_level", level, 9'd0);
    USB3_FLAGA = 1'b1;
    usb_rd_state = 4'd0;
    clear_err = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    dut_qv_cnt = 0;
    dut_done_cnt = 0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    started = 1;
    @(negedge clock);
    chk("init_level", level, 9'd0);
    chk("init_empty", empty, 1'b1);
    chk("init_q", q, 32'd0);
    chk("init_q_valid", q_valid, 1'b0);

    // full burst of 0..255
    fill(256, 0);
    chk("fill256_full", full, 1'b1);
    drop_flag(270);
    chk("b1_qv_cycles", dut_qv_cnt, 256);
    chk("b1_done_pulses", dut_done_cnt, 1);
    chk("b1_level", level, 9'd0);

    // wrap-around: 300 then 212 more
    do_reset();
    fill(300, 0);
    chk("w300_overflow", overflow, 1'b1);
    drop_flag(270);
    chk("w300_level_after", level, 9'd0);
    do_reset();
    fill(256, 0);
    drop_flag(270);
    fill(44, 256);
    fill(212, 300);
    chk("wrap_level_256", level, 9'd256);
    dut_qv_cnt = 0;
    drop_flag(270);
    chk("wrap_qv_cycles", dut_qv_cnt, 256);
    chk("wrap_level_end", level, 9'd0);

    // overflow and clear
    do_reset();
    fill(257, 0);
    chk("ovf_level", level, 9'd256);
    chk("ovf_full", full, 1'b1);
    chk("ovf_flag", overflow, 1'b1);
    @(negedge clock);
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);

    // underflow
    do_reset();
    fill(100, 0);
    drop_flag(20);
    chk("unf_flag", underflow, 1'b1);
    chk("unf_level", level, 9'd100);
    chk("unf_no_qv", dut_qv_cnt, 0);

    // continuous writes during a burst, with a second fall mid-burst
    do_reset();
    fill(256, 0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (i == 150) chk("stream_level_const", level, 9'd255);
      usb_rd_state = 4'd6;
      data = 32'(1000 + i);
      USB3_FLAGA = (i < 4 || (i >= 100 && i < 104)) ? 1'b0 : 1'b1;
    end
    usb_rd_state = 4'd0;
    repeat (10) @(negedge clock);
    chk("mid_fall_done_pulses", dut_done_cnt, 1);
    chk("mid_fall_qv_cycles", dut_qv_cnt, 256);

    // reset in the middle of a burst
    do_reset();
    fill(256, 0);
    @(negedge clock);
    USB3_FLAGA = 1'b0;
    repeat (13) @(negedge clock);
    do_reset();
    repeat (5) @(negedge clock);
    chk("abort_no_done", dut_done_cnt, 0);
    fill(256, 5000);
    drop_flag(270);
    chk("post_abort_qv", dut_qv_cnt, 256);
    chk("post_abort_done", dut_done_cnt, 1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      usb_rd_state = ($urandom_range(0, 2) != 0) ? 4'd6 : 4'($urandom_range(0, 15));
      data = $urandom;
      if ($urandom_range(0, 39) == 0) USB3_FLAGA = ~USB3_FLAGA;
      clear_err = ($urandom_range(0, 30) == 0);
    end
    usb_rd_state = 4'd0;
    clear_err = 1'b0;
    USB3_FLAGA = 1'b1;
    repeat (300) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
